// File: rtl/elevator_scheduler.sv
// LOOK-policy scheduler for a single elevator car: latches calls and drives updown/door_open.
// Define FIRE_RECALL_EN to add the `recall` input (fire recall to floor 1, door held open).
module elevator_scheduler #(
  parameter int unsigned NUM_FLOORS = 5,
  parameter int unsigned DOOR_HOLD  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [2:0]            car_floor,
  input  logic                  car_door,
`ifdef FIRE_RECALL_EN
  input  logic                  recall,
`endif
  output logic [1:0]            updown,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  fault
);

  localparam int unsigned CNT_W   = $clog2(DOOR_HOLD + 1);
  localparam logic [1:0]  UD_STOP = 2'b00;
  localparam logic [1:0]  UD_UP   = 2'b01;
  localparam logic [1:0]  UD_DOWN = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_UP, S_DOWN, S_STOP, S_OPEN, S_HOLD, S_CLOSE
  } state_t;

  state_t                state, state_n;
  logic [NUM_FLOORS-1:0] pend_n, latch_mask;
  logic [NUM_FLOORS-1:0] cur_hot, above_mask, below_mask;
  logic [CNT_W-1:0]      hold_cnt, cnt_n;
  logic [2:0]            entry_floor, entry_n, cur;
  logic                  dir_n, floor_valid, at_top, at_bottom;
  logic                  hit_cur, calls_above, calls_below, req_cur, door_phase;

  assign cur         = car_floor - 3'd1;
  assign floor_valid = (car_floor != 3'd0) && (car_floor <= 3'(NUM_FLOORS));
  assign at_top      = (car_floor == 3'(NUM_FLOORS));
  assign at_bottom   = (car_floor == 3'd1);

  // Floor-relative masks: the current floor, floors above it and floors below it.
  always_comb begin
    cur_hot    = '0;
    above_mask = '0;
    below_mask = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      cur_hot[i]    = floor_valid && (3'(i) == cur);
      above_mask[i] = (3'(i) > cur);
      below_mask[i] = (3'(i) < cur);
    end
  end

  assign hit_cur     = |(pending & cur_hot);
  assign calls_above = |(pending & above_mask);
  assign calls_below = |(pending & below_mask);
  assign req_cur     = |(call_req & cur_hot);
  assign door_phase  = (state == S_OPEN) || (state == S_HOLD);

  // Next state, call latching and hold countdown.
  always_comb begin
    state_n    = state;
    cnt_n      = hold_cnt;
    dir_n      = dir_up;
    entry_n    = entry_floor;
    latch_mask = (door_phase && floor_valid) ? (call_req & ~cur_hot) : call_req;
    pend_n     = pending | latch_mask;

    if (floor_valid) begin
      case (state)
        S_IDLE: begin
          if (hit_cur) begin
            state_n = S_OPEN;
          end else if (calls_above && (dir_up || !calls_below)) begin
            state_n = S_UP;
            dir_n   = 1'b1;
            entry_n = car_floor;
          end else if (calls_below) begin
            state_n = S_DOWN;
            dir_n   = 1'b0;
            entry_n = car_floor;
          end
        end
        S_UP: begin
          if (at_top || (hit_cur && (car_floor != entry_floor))) state_n = S_STOP;
        end
        S_DOWN: begin
          if (at_bottom || (hit_cur && (car_floor != entry_floor))) state_n = S_STOP;
        end
        S_STOP: state_n = S_OPEN;
        S_OPEN: begin
          if (car_door) begin
            pend_n  = pend_n & ~cur_hot;
            cnt_n   = CNT_W'(DOOR_HOLD);
            state_n = S_HOLD;
          end
        end
        S_HOLD: begin
          if (req_cur) begin
            cnt_n = CNT_W'(DOOR_HOLD);
          end else if (hold_cnt == '0) begin
            state_n = S_CLOSE;
          end else begin
            cnt_n = hold_cnt - CNT_W'(1);
          end
        end
        S_CLOSE: begin
          if (req_cur) begin
            state_n = S_OPEN;
          end else if (!car_door) begin
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
`ifdef FIRE_RECALL_EN
      // Recall overrides scheduling: close any door away from floor 1, descend, then park open.
      if (recall) begin
        case (state)
          S_IDLE: begin
            if (at_bottom) begin
              state_n = S_OPEN;
            end else begin
              state_n = S_DOWN;
              dir_n   = 1'b0;
              entry_n = car_floor;
            end
          end
          S_UP:   state_n = S_IDLE;
          S_DOWN: state_n = at_bottom ? S_STOP : S_DOWN;
          S_STOP: state_n = at_bottom ? S_OPEN : S_IDLE;
          S_OPEN: begin
            cnt_n   = CNT_W'(DOOR_HOLD);
            state_n = !at_bottom ? S_CLOSE : (car_door ? S_HOLD : S_OPEN);
          end
          S_HOLD: begin
            cnt_n   = CNT_W'(DOOR_HOLD);
            state_n = at_bottom ? S_HOLD : S_CLOSE;
          end
          S_CLOSE: state_n = car_door ? S_CLOSE : S_IDLE;
          default: state_n = S_IDLE;
        endcase
      end
`endif
    end else begin
      state_n = S_IDLE;
    end
`ifdef FIRE_RECALL_EN
    if (recall) pend_n = '0;
`endif
  end

  // State and registered car commands; commands follow the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pending     <= '0;
      updown      <= UD_STOP;
      door_open   <= 1'b0;
      dir_up      <= 1'b1;
      fault       <= 1'b0;
      hold_cnt    <= '0;
      entry_floor <= '0;
    end else begin
      state       <= state_n;
      pending     <= pend_n;
      hold_cnt    <= cnt_n;
      dir_up      <= dir_n;
      entry_floor <= entry_n;
      fault       <= !floor_valid;
      updown      <= (state_n == S_UP) ? UD_UP : ((state_n == S_DOWN) ? UD_DOWN : UD_STOP);
      door_open   <= (state_n == S_OPEN) || (state_n == S_HOLD);
    end
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Randomized scoreboard bench for elevator_scheduler with a simulated car and reference model.
`timescale 1ns/1ps
module tb_elevator_scheduler;

  localparam int unsigned NF   = 5;
  localparam int unsigned HOLD = 20;

  localparam int REST = 0, RISE = 1, FALL = 2, BRAKE = 3, OPENING = 4, DWELL = 5, CLOSING = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] call_req;
  logic [2:0] car_floor;
  logic       car_door;
  logic [1:0] updown;
  logic       door_open;
  logic [4:0] pending;
  logic       dir_up;
  logic       fault;

  elevator_scheduler #(.NUM_FLOORS(NF), .DOOR_HOLD(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .call_req  (call_req),
    .car_floor (car_floor),
    .car_door  (car_door),
    .updown    (updown),
    .door_open (door_open),
    .pending   (pending),
    .dir_up    (dir_up),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ud;
    logic       dopen;
    logic [4:0] pend;
    logic       dup;
    logic       flt;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp, mon_act;
  int   n_checks = 0, n_pass = 0, n_push = 0, n_pop = 0;

  // Reference model: calls per floor number, a travel mode and a dwell timer.
  int   m_mode, m_dwell, m_start;
  bit   m_calls [1:5];
  bit   m_up, m_flt;
  obs_t m_out;

  // Simulated car.
  int         cf, move_t, travel, door_t, door_dly, flt_left;
  bit         cd, prev_dopen;
  logic [2:0] flt_val;
  int         served[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, want);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      n_pop++;
      mon_act = {updown, door_open, pending, dir_up, fault};
      n_checks++;
      if (mon_act === mon_exp) n_pass++;
      else $display("FAIL scoreboard t=%0t got ud=%b door=%b pend=%b up=%b flt=%b, expected ud=%b door=%b pend=%b up=%b flt=%b",
                    $time, mon_act.ud, mon_act.dopen, mon_act.pend, mon_act.dup, mon_act.flt,
                    mon_exp.ud, mon_exp.dopen, mon_exp.pend, mon_exp.dup, mon_exp.flt);
    end
  end

  task automatic model_reset();
    m_mode  = REST;
    m_dwell = 0;
    m_start = 0;
    m_up    = 1'b1;
    m_flt   = 1'b0;
    for (int f = 1; f <= NF; f++) m_calls[f] = 1'b0;
    m_out   = '0;
    m_out.dup = 1'b1;
  endtask

  task automatic model_step(input logic [4:0] req, input int fl, input bit door);
    bit old [1:5];
    bit valid, any_up, any_dn;
    valid = (fl >= 1) && (fl <= NF);
    old   = m_calls;
    for (int f = 1; f <= NF; f++)
      if (req[f-1] && !(valid && f == fl && (m_mode == OPENING || m_mode == DWELL))) m_calls[f] = 1'b1;
    m_flt = !valid;
    if (!valid) begin
      m_mode = REST;
    end else begin
      any_up = 1'b0;
      any_dn = 1'b0;
      for (int f = 1; f <= NF; f++) begin
        if (old[f] && f > fl) any_up = 1'b1;
        if (old[f] && f < fl) any_dn = 1'b1;
      end
      case (m_mode)
        REST: begin
          if (old[fl]) m_mode = OPENING;
          else if (any_up && (m_up || !any_dn)) begin m_mode = RISE; m_up = 1'b1; m_start = fl; end
          else if (any_dn) begin m_mode = FALL; m_up = 1'b0; m_start = fl; end
        end
        RISE:    if (fl == NF || (old[fl] && fl != m_start)) m_mode = BRAKE;
        FALL:    if (fl == 1 || (old[fl] && fl != m_start)) m_mode = BRAKE;
        BRAKE:   m_mode = OPENING;
        OPENING: if (door) begin m_calls[fl] = 1'b0; m_dwell = HOLD; m_mode = DWELL; end
        DWELL: begin
          if (req[fl-1]) m_dwell = HOLD;
          else if (m_dwell == 0) m_mode = CLOSING;
          else m_dwell--;
        end
        CLOSING: begin
          if (req[fl-1]) m_mode = OPENING;
          else if (!door) m_mode = REST;
        end
        default: m_mode = REST;
      endcase
    end
    m_out.ud    = (m_mode == RISE) ? 2'b01 : ((m_mode == FALL) ? 2'b10 : 2'b00);
    m_out.dopen = (m_mode == OPENING) || (m_mode == DWELL);
    for (int f = 1; f <= NF; f++) m_out.pend[f-1] = m_calls[f];
    m_out.dup   = m_up;
    m_out.flt   = m_flt;
  endtask

  // Car obeys the model's commands with random travel and door delays.
  task automatic env_update();
    if (m_out.ud != 2'b00) begin
      move_t++;
      if (move_t >= travel) begin
        if (m_out.ud == 2'b01 && cf < NF) cf++;
        else if (m_out.ud == 2'b10 && cf > 1) cf--;
        move_t = 0;
        travel = $urandom_range(2, 4);
      end
    end else begin
      move_t = 0;
    end
    if (m_out.dopen != cd) begin
      door_t++;
      if (door_t >= door_dly) begin
        cd       = m_out.dopen;
        door_t   = 0;
        door_dly = $urandom_range(1, 3);
      end
    end else begin
      door_t = 0;
    end
    if (m_out.dopen && !prev_dopen) served.push_back(cf);
    prev_dopen = m_out.dopen;
  endtask

  task automatic tick(input logic [4:0] req);
    call_req  = req;
    car_floor = (flt_left > 0) ? flt_val : 3'(cf);
    car_door  = cd;
    if (flt_left > 0) flt_left--;
    model_step(req, int'(car_floor), cd);
    @(posedge clk);
    exp_q.push_back(m_out);
    n_push++;
    #1;
    env_update();
  endtask

  function automatic bit quiet();
    bit any;
    any = 1'b0;
    for (int f = 1; f <= NF; f++) any |= m_calls[f];
    return (m_mode == REST) && !any && !cd;
  endfunction

  task automatic run_to_mode(input int mode, input int budget, input string name);
    int n = 0;
    while (m_mode != mode && n < budget) begin tick('0); n++; end
    check(name, 32'(m_mode == mode), 32'd1);
  endtask

  task automatic run_to_quiet(input int budget, input string name);
    int n = 0;
    while (!quiet() && n < budget) begin tick('0); n++; end
    check(name, 32'(quiet()), 32'd1);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    check("mid_rst_updown",  32'(updown),    32'd0);
    check("mid_rst_door",    32'(door_open), 32'd0);
    check("mid_rst_pending", 32'(pending),   32'd0);
    n_push -= exp_q.size();
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    env_update();
  endtask

  initial begin
    logic [4:0] r;
    int         order, n;
    bit         did_rst;
    rst_n = 1'b1; call_req = '0; car_floor = 3'd1; car_door = 1'b0;
    cf = 1; cd = 1'b0; move_t = 0; travel = 2; door_t = 0; door_dly = 1;
    flt_left = 0; flt_val = 3'd0; prev_dopen = 1'b0; did_rst = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #2;
    check("rst_updown",  32'(updown),    32'd0);
    check("rst_door",    32'(door_open), 32'd0);
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_dir_up",  32'(dir_up),    32'd1);
    check("rst_fault",   32'(fault),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick('0);

    // Single call from floor 1 to floor 3.
    tick(5'b00100);
    check("latch", 32'(pending), 32'b00100);
    tick('0);
    check("launch", 32'(updown), 32'b01);
    run_to_mode(DWELL, 100, "reach_hold");
    check("served_clear", 32'(pending), 32'd0);
    repeat (20) tick('0);
    check("hold_20", 32'(door_open), 32'd1);
    run_to_quiet(100, "quiet_1");

    // Sweep up to 5 with simultaneous calls for 4 and 1.
    served.delete();
    tick(5'b10000);
    run_to_mode(RISE, 20, "sweep_start");
    tick(5'b01001);
    run_to_quiet(600, "quiet_sweep");
    order = (served.size() == 3) ? served[0] * 100 + served[1] * 10 + served[2] : -1;
    check("serve_order", 32'(order), 32'd451);
    check("reversed", 32'(dir_up), 32'd0);

    // Hold reload from a call at the open floor.
    tick(5'b00100);
    run_to_mode(DWELL, 200, "reach_hold_3");
    n = 0;
    while (m_dwell != 3 && n < 40) begin tick('0); n++; end
    check("hold_at_3", 32'(m_dwell), 32'd3);
    tick(5'b00100);
    check("no_relatch", 32'(pending), 32'd0);
    repeat (20) tick('0);
    check("reload_hold", 32'(door_open), 32'd1);
    run_to_quiet(100, "quiet_2");

    // Invalid floor during travel.
    tick(5'b10000);
    run_to_mode(RISE, 20, "fault_rise");
    flt_left = 2;
    flt_val  = 3'd0;
    tick('0);
    check("fault_set",  32'(fault),  32'd1);
    check("fault_stop", 32'(updown), 32'd0);
    tick('0);
    tick('0);
    check("fault_clear", 32'(fault),  32'd0);
    check("resume",      32'(updown), 32'b01);
    run_to_quiet(300, "quiet_3");

    // Random traffic with occasional floor faults and one reset while moving.
    for (int k = 0; k < 2500; k++) begin
      r = '0;
      if ($urandom_range(0, 5) == 0) r = 5'($urandom_range(1, 31));
      if (flt_left == 0 && $urandom_range(0, 199) == 0) begin
        flt_left = $urandom_range(1, 3);
        case ($urandom_range(0, 2))
          0:       flt_val = 3'd0;
          1:       flt_val = 3'd6;
          default: flt_val = 3'd7;
        endcase
      end
      if (k >= 1200 && !did_rst && (m_mode == RISE || m_mode == FALL)) begin
        mid_reset();
        did_rst = 1'b1;
      end
      tick(r);
    end
    run_to_quiet(3000, "drain");
    @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(n_pop), 32'(n_push));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
